// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the 5-stage pipeline sequencing controller:
//   - controller FSM state encoding
//   - operand-forwarding select codes (same values as the datapath's
//     EXE_*_FWD_* mux codes)
//   - per-stage rst/en control bundle and helpers to build it
// No ports (package).
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_STAGES = 5;

  // Stage indices into pipe_ctrl_t
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } ctrl_state_e;

  // Forwarding select codes. FWD_MEMOUT is reserved: the datapath supports
  // it but this controller never drives it.
  localparam logic [1:0] FWD_ALUOUT = 2'd0;
  localparam logic [1:0] FWD_MEMOUT = 2'd1;
  localparam logic [1:0] FWD_WB     = 2'd2;
  localparam logic [1:0] FWD_REG    = 2'd3;

  typedef struct packed {
    logic rst;
    logic en;
  } stage_ctrl_t;

  typedef stage_ctrl_t [NUM_STAGES-1:0] pipe_ctrl_t;

  // Same rst/en pair on every stage.
  function automatic pipe_ctrl_t pipe_all(input logic rst, input logic en);
    pipe_ctrl_t c;
    for (int i = 0; i < NUM_STAGES; i++) begin
      c[i].rst = rst;
      c[i].en  = en;
    end
    return c;
  endfunction

  // Memory freeze: every stage holds, WB takes a bubble so the instruction
  // stuck in MEM is not retired twice.
  function automatic pipe_ctrl_t pipe_mem_stall();
    pipe_ctrl_t c;
    c = pipe_all(1'b0, 1'b0);
    c[STG_WB].rst = 1'b1;
    c[STG_WB].en  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundle between the datapath/decoder side (master) and the sequencing
// controller (slave).
//   master drives : ID operand info, EXE/MEM producer info, branch flags,
//                   data-memory request/ack
//   slave drives  : per-stage rst/en, forwarding selects, halted
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  // ID-stage consumer
  logic [REG_ADDR_W-1:0] addr_rs_id;
  logic [REG_ADDR_W-1:0] addr_rt_id;
  logic                  rs_used_id;
  logic                  rt_used_id;
  logic                  is_branch_id;
  // EXE / MEM producers
  logic                  is_branch_exe;
  logic                  is_branch_mem;
  logic [REG_ADDR_W-1:0] regw_addr_exe;
  logic [REG_ADDR_W-1:0] regw_addr_mem;
  logic                  wb_wen_exe;
  logic                  wb_wen_mem;
  logic                  mem_ren_exe;
  // Data memory handshake
  logic                  mem_req;
  logic                  mem_ack;
  // Stage controls
  logic                  if_rst,  if_en;
  logic                  id_rst,  id_en;
  logic                  exe_rst, exe_en;
  logic                  mem_rst, mem_en;
  logic                  wb_rst,  wb_en;
  // Forwarding and status
  logic [1:0]            exe_fwd_a_ctrl;
  logic [1:0]            exe_fwd_b_ctrl;
  logic                  halted;

  modport master (
    output addr_rs_id, addr_rt_id, rs_used_id, rt_used_id, is_branch_id,
           is_branch_exe, is_branch_mem, regw_addr_exe, regw_addr_mem,
           wb_wen_exe, wb_wen_mem, mem_ren_exe, mem_req, mem_ack,
    input  if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en,
           wb_rst, wb_en, exe_fwd_a_ctrl, exe_fwd_b_ctrl, halted
  );

  modport slave (
    input  addr_rs_id, addr_rt_id, rs_used_id, rt_used_id, is_branch_id,
           is_branch_exe, is_branch_mem, regw_addr_exe, regw_addr_mem,
           wb_wen_exe, wb_wen_mem, mem_ren_exe, mem_req, mem_ack,
    output if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en,
           wb_rst, wb_en, exe_fwd_a_ctrl, exe_fwd_b_ctrl, halted
  );

endinterface

// File: rtl/pipeline_ctrl_fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
// Forwarding select for one source operand of the instruction in ID.
// Pure combinational; instantiated once for rs and once for rt.
//   addr_i     : source register number
//   used_i     : instruction actually reads this operand
//   exe_addr_i : destination of the instruction in EXE
//   exe_wen_i  : EXE instruction writes the register file
//   mem_addr_i : destination of the instruction in MEM
//   mem_wen_i  : MEM instruction writes the register file
//   sel_o      : FWD_ALUOUT / FWD_WB / FWD_REG
// ---------------------------------------------------------------------------
module fwd_sel
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic                  used_i,
  input  logic [REG_ADDR_W-1:0] exe_addr_i,
  input  logic                  exe_wen_i,
  input  logic [REG_ADDR_W-1:0] mem_addr_i,
  input  logic                  mem_wen_i,
  output logic [1:0]            sel_o
);

  // The select is registered by the datapath, so an EXE producer is in MEM
  // (ALU result) and a MEM producer is in WB when the consumer reaches EXE.
  // The EXE producer is younger and therefore holds the live value.
  always_comb begin
    sel_o = FWD_REG;
    if (used_i && (addr_i != '0)) begin
      if (exe_wen_i && (exe_addr_i == addr_i)) begin
        sel_o = FWD_ALUOUT;
      end else if (mem_wen_i && (mem_addr_i == addr_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Sequencing controller for the 5-stage MIPS datapath: holds all stages in
// reset after rst, inserts load-use bubbles, squashes wrong-path fetches
// around branches/jumps (resolved in MEM), freezes the pipe while data
// memory is busy, halts on a memory timeout, and produces the operand
// forwarding selects for the instruction in ID.
// Ports:
//   clk      : core clock
//   rst      : asynchronous active-high reset
//   ctrl_if  : pipeline_ctrl_if.slave (hazard inputs, stage controls,
//              forwarding selects, halted)
// Only state, counter and halted are registered; stage controls and
// forwarding selects are combinational from state and inputs.
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_ctrl_if.slave    ctrl_if
);

  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_inc;

  pipe_ctrl_t       pipe_ctrl;
  logic             run_cycle;
  logic             fwd_force_reg;

  // -------------------------------------------------------------------------
  // Forwarding selects: one fwd_sel per source operand (0 = rs, 1 = rt)
  // -------------------------------------------------------------------------
  logic [REG_ADDR_W-1:0] op_addr [2];
  logic                  op_used [2];
  logic [1:0]            op_sel  [2];

  assign op_addr[0] = ctrl_if.addr_rs_id;
  assign op_addr[1] = ctrl_if.addr_rt_id;
  assign op_used[0] = ctrl_if.rs_used_id;
  assign op_used[1] = ctrl_if.rt_used_id;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_sel u_fwd_sel (
      .addr_i     (op_addr[gi]),
      .used_i     (op_used[gi]),
      .exe_addr_i (ctrl_if.regw_addr_exe),
      .exe_wen_i  (ctrl_if.wb_wen_exe),
      .mem_addr_i (ctrl_if.regw_addr_mem),
      .mem_wen_i  (ctrl_if.wb_wen_mem),
      .sel_o      (op_sel[gi])
    );
  end

  // -------------------------------------------------------------------------
  // Load-use detection: a load in EXE whose destination is read by ID cannot
  // be forwarded in time, so one bubble is inserted into EXE.
  // -------------------------------------------------------------------------
  logic rs_hit, rt_hit, load_use;

  assign rs_hit   = ctrl_if.rs_used_id && (ctrl_if.addr_rs_id == ctrl_if.regw_addr_exe);
  assign rt_hit   = ctrl_if.rt_used_id && (ctrl_if.addr_rt_id == ctrl_if.regw_addr_exe);
  assign load_use = ctrl_if.mem_ren_exe && ctrl_if.wb_wen_exe &&
                    (ctrl_if.regw_addr_exe != '0) && (rs_hit || rt_hit);

  assign cnt_inc = cnt_q + 1'b1;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and stage controls
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    halted_d      = halted_q;
    pipe_ctrl     = pipe_all(1'b0, 1'b1);
    run_cycle     = 1'b0;
    fwd_force_reg = 1'b0;

    case (state_q)
      ST_INIT: begin
        pipe_ctrl     = pipe_all(1'b1, 1'b0);
        fwd_force_reg = 1'b1;
        if (cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RUN: begin
        if (ctrl_if.mem_req && !ctrl_if.mem_ack) begin
          pipe_ctrl = pipe_mem_stall();
          state_d   = ST_MEM_WAIT;
          cnt_d     = '0;
        end else begin
          run_cycle = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (ctrl_if.mem_ack) begin
          // The access completes and the pipe advances as in a normal RUN
          // cycle, hazard handling included: the ID instruction may still
          // depend on a load in EXE or be squashed by a branch.
          state_d   = ST_RUN;
          cnt_d     = '0;
          run_cycle = 1'b1;
        end else begin
          pipe_ctrl = pipe_mem_stall();
          cnt_d     = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end
      end

      ST_HALT: begin
        // Everything frozen (not reset) so the pipe contents can be inspected.
        pipe_ctrl = pipe_all(1'b0, 1'b0);
        halted_d  = 1'b1;
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    // Hazards, highest priority first; a lower item is masked by a higher.
    if (run_cycle) begin
      if (ctrl_if.is_branch_mem) begin
        // PC loads the resolved target; the wrong-path instruction in IF is
        // killed on its way into ID.
        pipe_ctrl[STG_IF].en  = 1'b1;
        pipe_ctrl[STG_ID].rst = 1'b1;
      end else if (load_use) begin
        // Hold IF and ID, bubble into EXE. The load moves to MEM, so the
        // condition clears by itself next cycle.
        pipe_ctrl[STG_IF].en  = 1'b0;
        pipe_ctrl[STG_ID].en  = 1'b0;
        pipe_ctrl[STG_EXE].rst = 1'b1;
      end else if (ctrl_if.is_branch_exe || ctrl_if.is_branch_id) begin
        // Branch still unresolved: stop fetching and squash what is behind
        // it; the branch itself keeps moving down the pipe.
        pipe_ctrl[STG_IF].en  = 1'b0;
        pipe_ctrl[STG_ID].rst = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ctrl_if.if_rst  = pipe_ctrl[STG_IF].rst;
  assign ctrl_if.if_en   = pipe_ctrl[STG_IF].en;
  assign ctrl_if.id_rst  = pipe_ctrl[STG_ID].rst;
  assign ctrl_if.id_en   = pipe_ctrl[STG_ID].en;
  assign ctrl_if.exe_rst = pipe_ctrl[STG_EXE].rst;
  assign ctrl_if.exe_en  = pipe_ctrl[STG_EXE].en;
  assign ctrl_if.mem_rst = pipe_ctrl[STG_MEM].rst;
  assign ctrl_if.mem_en  = pipe_ctrl[STG_MEM].en;
  assign ctrl_if.wb_rst  = pipe_ctrl[STG_WB].rst;
  assign ctrl_if.wb_en   = pipe_ctrl[STG_WB].en;

  assign ctrl_if.exe_fwd_a_ctrl = fwd_force_reg ? FWD_REG : op_sel[0];
  assign ctrl_if.exe_fwd_b_ctrl = fwd_force_reg ? FWD_REG : op_sel[1];
  assign ctrl_if.halted         = halted_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl. A behavioural model (phase counters and
// plain hazard rules) predicts every output on every falling edge; directed
// sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int INIT_CYCLES = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 8;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .INIT_CYCLES (INIT_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  int m_init_left = INIT_CYCLES;  // INIT cycles still to come
  bit m_waiting   = 1'b0;         // data memory access outstanding
  int m_wait_n    = 0;            // unacknowledged cycles spent waiting
  bit m_halted    = 1'b0;

  function automatic logic [1:0] fwd_model(input logic [4:0] a, input logic used);
    if (!used || a == 5'd0) return 2'd3;
    if (bus.wb_wen_exe && a == bus.regw_addr_exe) return 2'd0;
    if (bus.wb_wen_mem && a == bus.regw_addr_mem) return 2'd2;
    return 2'd3;
  endfunction

  // {if_rst,if_en,id_rst,id_en,exe_rst,exe_en,mem_rst,mem_en,wb_rst,wb_en,fa,fb,halted}
  function automatic logic [14:0] model_out();
    logic [9:0] sc;
    logic [1:0] fa, fb;
    logic       h;
    bit         stall, lu;
    fa = fwd_model(bus.addr_rs_id, bus.rs_used_id);
    fb = fwd_model(bus.addr_rt_id, bus.rt_used_id);
    h  = m_halted;
    if (rst || m_init_left > 0) begin
      sc = 10'b10_10_10_10_10;
      fa = 2'd3;
      fb = 2'd3;
      h  = 1'b0;
    end else if (m_halted) begin
      sc = 10'b00_00_00_00_00;
    end else begin
      stall = m_waiting ? !bus.mem_ack : (bus.mem_req && !bus.mem_ack);
      lu = bus.mem_ren_exe && bus.wb_wen_exe && bus.regw_addr_exe != 5'd0 &&
           ((bus.rs_used_id && bus.addr_rs_id == bus.regw_addr_exe) ||
            (bus.rt_used_id && bus.addr_rt_id == bus.regw_addr_exe));
      if (stall)                                  sc = 10'b00_00_00_00_11;
      else if (bus.is_branch_mem)                 sc = 10'b01_11_01_01_01;
      else if (lu)                                sc = 10'b00_00_11_01_01;
      else if (bus.is_branch_exe || bus.is_branch_id) sc = 10'b00_11_01_01_01;
      else                                        sc = 10'b01_01_01_01_01;
    end
    return {sc, fa, fb, h};
  endfunction

  task automatic model_advance();
    if (rst) begin
      m_init_left = INIT_CYCLES;
      m_waiting   = 1'b0;
      m_halted    = 1'b0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else if (!m_halted) begin
      if (m_waiting) begin
        if (bus.mem_ack) m_waiting = 1'b0;
        else begin
          m_wait_n++;
          if (m_wait_n == MEM_TIMEOUT) begin
            m_halted  = 1'b1;
            m_waiting = 1'b0;
          end
        end
      end else if (bus.mem_req && !bus.mem_ack) begin
        m_waiting = 1'b1;
        m_wait_n  = 0;
      end
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    logic [14:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      exp_v = model_out();
      act_v = {bus.if_rst, bus.if_en, bus.id_rst, bus.id_en, bus.exe_rst, bus.exe_en,
               bus.mem_rst, bus.mem_en, bus.wb_rst, bus.wb_en,
               bus.exe_fwd_a_ctrl, bus.exe_fwd_b_ctrl, bus.halted};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cycle t=%0t actual=%b required=%b", $time, act_v, exp_v);
      end
      model_advance();
    end
  end

  // ---------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic idle();
    bus.addr_rs_id = '0;  bus.addr_rt_id = '0;
    bus.rs_used_id = 1'b0; bus.rt_used_id = 1'b0;
    bus.is_branch_id = 1'b0; bus.is_branch_exe = 1'b0; bus.is_branch_mem = 1'b0;
    bus.regw_addr_exe = '0; bus.regw_addr_mem = '0;
    bus.wb_wen_exe = 1'b0; bus.wb_wen_mem = 1'b0; bus.mem_ren_exe = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count INIT cycles after rst release; ends at the first RUN negedge.
  task automatic count_init(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.if_rst && bus.if_en) break;
      n++;
    end
    chk(name, n, INIT_CYCLES);
    chk({name, "_halted"}, bus.halted, 0);
    tick();
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic rs_u, input logic rt_u);
    bus.addr_rs_id = rs; bus.addr_rt_id = rt;
    bus.rs_used_id = rs_u; bus.rt_used_id = rt_u;
  endtask

  task automatic set_prod(input logic [4:0] ea, input logic ew, input logic eload,
                          input logic [4:0] ma, input logic mw);
    bus.regw_addr_exe = ea; bus.wb_wen_exe = ew; bus.mem_ren_exe = eload;
    bus.regw_addr_mem = ma; bus.wb_wen_mem = mw;
  endtask

  // ---------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------
  initial begin
    int n_if0, n_idrst, n_wbrst, n;
    logic b_id [4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic b_exe [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic b_mem [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic ack_seq [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rst_all", {bus.if_rst, bus.id_rst, bus.exe_rst, bus.mem_rst, bus.wb_rst}, 5'h1F);
    chk("reset_en_all", {bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_en}, 5'h00);
    chk("reset_fwd", {bus.exe_fwd_a_ctrl, bus.exe_fwd_b_ctrl}, 4'hF);
    chk("reset_halted", bus.halted, 0);
    @(posedge clk); #1 rst = 1'b0;
    count_init("init_len");

    // ALU chain: add $1 in EXE, add $2,$1,$1 in ID
    set_id(5'd1, 5'd1, 1'b1, 1'b1); set_prod(5'd1, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("alu_fwd_exe", {bus.exe_fwd_a_ctrl, bus.exe_fwd_b_ctrl}, 4'h0);
    chk("alu_nostall", {bus.if_en, bus.id_en, bus.exe_rst}, 3'b110);
    tick();
    // one instruction in between: producer now in MEM
    set_prod(5'd5, 1'b1, 1'b0, 5'd1, 1'b1);
    @(negedge clk);
    chk("alu_fwd_mem", {bus.exe_fwd_a_ctrl, bus.exe_fwd_b_ctrl}, 4'hA);
    tick();
    // $0 never forwarded
    set_id(5'd0, 5'd1, 1'b1, 1'b1); set_prod(5'd0, 1'b1, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    chk("fwd_reg0", {bus.exe_fwd_a_ctrl, bus.exe_fwd_b_ctrl}, 4'hF);
    tick();
    // EXE match beats MEM match; unused operand reads the register file
    set_id(5'd4, 5'd4, 1'b1, 1'b0); set_prod(5'd4, 1'b1, 1'b0, 5'd4, 1'b1);
    @(negedge clk);
    chk("fwd_exe_wins", {bus.exe_fwd_a_ctrl, bus.exe_fwd_b_ctrl}, 4'h3);
    tick();

    // Load-use: lw $3 in EXE, ID reads $3 via rt
    set_id(5'd7, 5'd3, 1'b1, 1'b1); set_prod(5'd3, 1'b1, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    chk("lu_bubble", {bus.if_en, bus.id_en, bus.exe_rst}, 3'b001);
    tick();
    set_prod(5'd0, 1'b0, 1'b0, 5'd3, 1'b1);
    @(negedge clk);
    chk("lu_after", {bus.if_en, bus.id_en, bus.exe_rst, bus.exe_fwd_b_ctrl}, 5'b110_10);
    tick();
    set_id(5'd7, 5'd3, 1'b1, 1'b0); set_prod(5'd3, 1'b1, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    chk("lu_rt_unused", {bus.if_en, bus.id_en, bus.exe_rst}, 3'b110);
    tick();
    idle();

    // Branch travelling ID -> EXE -> MEM
    n_if0 = 0; n_idrst = 0;
    for (int c = 0; c < 4; c++) begin
      bus.is_branch_id = b_id[c]; bus.is_branch_exe = b_exe[c]; bus.is_branch_mem = b_mem[c];
      @(negedge clk);
      if (!bus.if_en) n_if0++;
      if (bus.id_rst) n_idrst++;
      if (c == 2) chk("br_mem_fetch", {bus.if_en, bus.id_rst}, 2'b11);
      tick();
    end
    chk("br_if_hold", n_if0, 2);
    chk("br_id_squash", n_idrst, 3);
    idle();

    // Memory wait: three unacked cycles, then ack
    n_wbrst = 0;
    for (int c = 0; c < 4; c++) begin
      bus.mem_req = 1'b1; bus.mem_ack = ack_seq[c];
      @(negedge clk);
      if (bus.wb_rst) n_wbrst++;
      if (c == 3) chk("mw_ack_advance", {bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_rst}, 5'b11110);
      tick();
    end
    chk("mw_frozen", n_wbrst, 3);
    bus.mem_req = 1'b1; bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("mw_req_ack", {bus.if_en, bus.wb_rst}, 2'b10);
    tick();
    idle();

    // Reset in the middle of MEM_WAIT
    bus.mem_req = 1'b1;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {bus.if_rst, bus.id_rst, bus.exe_rst, bus.mem_rst, bus.wb_rst,
                      bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_en}, 10'b11111_00000);
    @(posedge clk); #1 rst = 1'b0;
    idle();
    count_init("init_after_rst");

    // Timeout: ack never arrives
    bus.mem_req = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.halted) break;
      n++;
      tick();
    end
    chk("to_cycles", n, MEM_TIMEOUT + 1);
    chk("halt_ctrl", {bus.if_rst, bus.id_rst, bus.exe_rst, bus.mem_rst, bus.wb_rst,
                      bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_en}, 10'b0);
    tick();
    idle();
    repeat (3) tick();
    @(negedge clk);
    chk("halt_sticky", bus.halted, 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("halt_cleared", bus.halted, 0);
    @(posedge clk); #1 rst = 1'b0;
    count_init("init_after_halt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
